// File: rtl/enc_pkg.sv
// enc_pkg: shared definitions for the iterative word cipher.
//   MODE_ENC / MODE_DEC : transaction direction as carried on in_mode
//   state_t             : engine FSM states
//   perm(x, width)      : bit permutation on the low 'width' bits of x
//   rotl(k, n, width)   : rotate the low 'width' bits of k left by n (n < width)
// The functions work on MAX_WIDTH-wide vectors. Callers zero-extend their
// operands and truncate the result back to their own width.
package enc_pkg;

    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

    localparam int unsigned MAX_WIDTH = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Even bits are inverted in place, odd bits are mirrored. Applying it
    // twice gives back the original word.
    function automatic logic [MAX_WIDTH-1:0] perm(input logic [MAX_WIDTH-1:0] x,
                                                  input int unsigned width);
        logic [MAX_WIDTH-1:0] y;
        y = '0;
        for (int unsigned i = 0; i < MAX_WIDTH; i++) begin
            if (i < width) begin
                y[i] = i[0] ? x[width-1-i] : ~x[i];
            end
        end
        return y;
    endfunction

    function automatic logic [MAX_WIDTH-1:0] rotl(input logic [MAX_WIDTH-1:0] k,
                                                  input int unsigned n,
                                                  input int unsigned width);
        logic [MAX_WIDTH-1:0] y;
        int unsigned j;
        y = '0;
        for (int unsigned i = 0; i < MAX_WIDTH; i++) begin
            if (i < width) begin
                j = i + n;
                if (j >= width) begin
                    j = j - width;
                end
                y[j] = k[i];
            end
        end
        return y;
    endfunction

endpackage

// File: rtl/enc_round.sv
// enc_round: one cipher round, purely combinational.
//   x    : round input word
//   k    : round key
//   mode : MODE_ENC -> y = P(x) ^ k ; MODE_DEC -> y = P(x ^ k)
//   y    : round output word
module enc_round
    import enc_pkg::*;
#(
    parameter int unsigned WIDTH = 19
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] k,
    input  logic             mode,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        if (mode == MODE_ENC) begin
            y = WIDTH'(perm(MAX_WIDTH'(x), WIDTH)) ^ k;
        end else begin
            y = WIDTH'(perm(MAX_WIDTH'(x ^ k), WIDTH));
        end
    end

endmodule

// File: rtl/enc_round_engine.sv
// enc_round_engine: iterative multi-round word cipher, one round per clock.
//   clk, rst_n         : clock, asynchronous active-low reset
//   key_load, key_in   : replace the key register (only while IDLE)
//   in_valid/in_ready  : input handshake; in_mode (0 enc, 1 dec), in_data
//   out_valid/out_ready: output handshake; out_data held until taken
//   busy               : engine is not IDLE
module enc_round_engine
    import enc_pkg::*;
#(
    parameter int unsigned      WIDTH       = 19,
    parameter int unsigned      ROUNDS      = 4,
    parameter logic [WIDTH-1:0] KEY_DEFAULT = 19'b1110011001011110010
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_load,
    input  logic [WIDTH-1:0] key_in,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_mode,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    if (WIDTH < 3 || WIDTH % 2 == 0 || WIDTH > MAX_WIDTH) begin : g_bad_width
        $error("enc_round_engine: WIDTH must be odd, >= 3 and <= MAX_WIDTH");
    end
    if (ROUNDS < 1 || ROUNDS > 31) begin : g_bad_rounds
        $error("enc_round_engine: ROUNDS must be in 1..31");
    end

    localparam int unsigned    CW   = $clog2(ROUNDS + 1);
    localparam logic [CW-1:0]  LAST = CW'(ROUNDS - 1);

    state_t           state;
    logic [WIDTH-1:0] key;
    logic [WIDTH-1:0] key_snap;
    logic [WIDTH-1:0] x_reg;
    logic             mode_r;
    logic [CW-1:0]    cnt;

    int unsigned      rot_amt;
    logic [WIDTH-1:0] round_key;
    logic [WIDTH-1:0] x_next;
    logic             last_round;

    always_comb begin
        rot_amt    = 32'(cnt) % WIDTH;
        round_key  = WIDTH'(rotl(MAX_WIDTH'(key_snap), rot_amt, WIDTH));
        // Encrypt walks the counter up to ROUNDS-1, decrypt walks it down to 0.
        last_round = (mode_r == MODE_ENC) ? (cnt == LAST) : (cnt == '0);
    end

    enc_round #(.WIDTH(WIDTH)) u_round (
        .x    (x_reg),
        .k    (round_key),
        .mode (mode_r),
        .y    (x_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            key       <= KEY_DEFAULT;
            key_snap  <= KEY_DEFAULT;
            x_reg     <= '0;
            mode_r    <= MODE_ENC;
            cnt       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // A key load coinciding with an accept still lets the
                    // snapshot take the old key (non-blocking read).
                    if (key_load) begin
                        key <= key_in;
                    end
                    if (in_valid) begin
                        x_reg    <= in_data;
                        mode_r   <= in_mode;
                        key_snap <= key;
                        cnt      <= (in_mode == MODE_ENC) ? '0 : LAST;
                        state    <= RUN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    x_reg <= x_next;
                    if (last_round) begin
                        out_data  <= x_next;
                        out_valid <= 1'b1;
                        cnt       <= '0;
                        state     <= DONE;
                    end else if (mode_r == MODE_ENC) begin
                        cnt <= cnt + CW'(1);
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_enc_round_engine.sv
module tb_enc_round_engine;

    localparam logic [18:0] KDEF = 19'b1110011001011110010;

    logic        clk;
    logic        rst_n     [3];
    logic        key_load  [3];
    logic [18:0] key_in    [3];
    logic        in_valid  [3];
    logic        in_mode   [3];
    logic [18:0] in_data   [3];
    logic        out_ready [3];
    logic        in_ready  [3];
    logic        out_valid [3];
    logic [18:0] out_data  [3];
    logic        busy      [3];

    logic [18:0] kmod [3];
    int vecs = 0;
    int errs = 0;

    enc_round_engine #(.WIDTH(19), .ROUNDS(1), .KEY_DEFAULT(KDEF)) u_r1 (
        .clk(clk), .rst_n(rst_n[0]), .key_load(key_load[0]), .key_in(key_in[0]),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_mode(in_mode[0]),
        .in_data(in_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_data(out_data[0]), .busy(busy[0]));

    enc_round_engine #(.WIDTH(19), .ROUNDS(4), .KEY_DEFAULT(KDEF)) u_r4 (
        .clk(clk), .rst_n(rst_n[1]), .key_load(key_load[1]), .key_in(key_in[1]),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_mode(in_mode[1]),
        .in_data(in_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_data(out_data[1]), .busy(busy[1]));

    enc_round_engine #(.WIDTH(19), .ROUNDS(25), .KEY_DEFAULT(KDEF)) u_r25 (
        .clk(clk), .rst_n(rst_n[2]), .key_load(key_load[2]), .key_in(key_in[2]),
        .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_mode(in_mode[2]),
        .in_data(in_data[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .out_data(out_data[2]), .busy(busy[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: straight from the cipher's definition.
    function automatic logic [18:0] m_perm(input logic [18:0] x);
        logic [18:0] y;
        for (int i = 0; i < 19; i++) y[i] = (i % 2 == 0) ? ~x[i] : x[18-i];
        return y;
    endfunction

    function automatic logic [18:0] m_rk(input logic [18:0] key, input int r);
        logic [37:0] dd;
        int n;
        n  = r % 19;
        dd = {key, key};
        dd = dd >> (19 - n);
        return dd[18:0];
    endfunction

    function automatic logic [18:0] m_run(input logic [18:0] x, input logic [18:0] key,
                                          input int rounds, input logic mode);
        logic [18:0] v;
        v = x;
        if (!mode) begin
            for (int r = 0; r < rounds; r++) v = m_perm(v) ^ m_rk(key, r);
        end else begin
            for (int r = rounds - 1; r >= 0; r--) v = m_perm(v ^ m_rk(key, r));
        end
        return v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One complete transaction on instance d, starting and ending at a negedge.
    task automatic txn(input int d, input logic [18:0] x, input logic mode,
                       input logic kl_acc, input logic kl_run, input logic [18:0] kin,
                       input int hold, output logic [18:0] res, output int lat);
        int n;
        in_data[d]  = x;
        in_mode[d]  = mode;
        in_valid[d] = 1'b1;
        key_load[d] = kl_acc;
        key_in[d]   = kin;
        n = 0;
        while (!in_ready[d] && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("accept_wait", 32'(n < 50), 1);
        @(posedge clk);
        @(negedge clk);
        in_valid[d] = 1'b0;
        key_load[d] = kl_run;
        n = 0;
        while (!out_valid[d] && n < 100) begin
            @(negedge clk);
            key_load[d] = 1'b0;
            n++;
        end
        key_load[d] = 1'b0;
        check("result_wait", 32'(n < 100), 1);
        lat = n;
        res = out_data[d];
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_data", 32'(out_data[d]), 32'(res));
            check("hold_valid", 32'(out_valid[d]), 1);
            check("hold_in_ready", 32'(in_ready[d]), 0);
        end
        out_ready[d] = 1'b1;
        @(negedge clk);
        out_ready[d] = 1'b0;
        check("done_valid_drop", 32'(out_valid[d]), 0);
        check("done_in_ready", 32'(in_ready[d]), 1);
        check("done_busy", 32'(busy[d]), 0);
    endtask

    initial begin
        logic [18:0] res, res2, x, k;
        int lat;

        for (int d = 0; d < 3; d++) begin
            rst_n[d] = 1'b0; key_load[d] = 1'b0; key_in[d] = '0; in_valid[d] = 1'b0;
            in_mode[d] = 1'b0; in_data[d] = '0; out_ready[d] = 1'b0; kmod[d] = KDEF;
        end
        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check("rst_out_valid", 32'(out_valid[d]), 0);
            check("rst_busy", 32'(busy[d]), 0);
            check("rst_in_ready", 32'(in_ready[d]), 1);
            check("rst_out_data", 32'(out_data[d]), 0);
        end
        for (int d = 0; d < 3; d++) rst_n[d] = 1'b1;
        @(negedge clk);

        // Legacy parity, ROUNDS=1
        txn(0, 19'h00000, 1'b0, 1'b0, 1'b0, '0, 0, res, lat);
        check("legacy_enc", 32'(res), 32'h267A7);
        check("legacy_lat", 32'(lat), 1);
        txn(0, 19'h267A7, 1'b1, 1'b0, 1'b0, '0, 0, res, lat);
        check("legacy_dec", 32'(res), 32'h00000);

        // ROUNDS=4: latency and output hold under back-pressure
        x = 19'($urandom);
        txn(1, x, 1'b0, 1'b0, 1'b0, '0, 5, res, lat);
        check("r4_hold_enc", 32'(res), 32'(m_run(x, kmod[1], 4, 1'b0)));
        check("r4_latency", 32'(lat), 4);

        // key_load coinciding with accept uses the old key
        txn(1, 19'h00001, 1'b0, 1'b1, 1'b0, 19'h12345, 0, res, lat);
        check("kl_accept_old_key", 32'(res), 32'(m_run(19'h00001, KDEF, 4, 1'b0)));
        kmod[1] = 19'h12345;
        txn(1, 19'h00001, 1'b0, 1'b0, 1'b0, '0, 0, res, lat);
        check("kl_next_new_key", 32'(res), 32'(m_run(19'h00001, 19'h12345, 4, 1'b0)));

        // key_load during RUN is ignored
        x = 19'($urandom);
        txn(1, x, 1'b0, 1'b0, 1'b1, 19'h6AAAA, 0, res, lat);
        check("kl_run_inflight", 32'(res), 32'(m_run(x, kmod[1], 4, 1'b0)));
        txn(1, x, 1'b0, 1'b0, 1'b0, '0, 0, res, lat);
        check("kl_run_key_kept", 32'(res), 32'(m_run(x, kmod[1], 4, 1'b0)));

        // Reset in the middle of RUN
        in_data[1] = 19'h0F0F0; in_mode[1] = 1'b0; in_valid[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid[1] = 1'b0;
        @(negedge clk);
        rst_n[1] = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("rst_mid_valid", 32'(out_valid[1]), 0);
        end
        rst_n[1] = 1'b1;
        kmod[1] = KDEF;
        repeat (6) begin
            @(negedge clk);
            check("post_rst_valid", 32'(out_valid[1]), 0);
            check("post_rst_in_ready", 32'(in_ready[1]), 1);
            check("post_rst_busy", 32'(busy[1]), 0);
        end
        txn(1, 19'h00001, 1'b0, 1'b0, 1'b0, '0, 0, res, lat);
        check("post_rst_default_key", 32'(res), 32'(m_run(19'h00001, KDEF, 4, 1'b0)));

        // Random round trips with periodic key changes
        for (int i = 0; i < 1000; i++) begin
            if (i % 100 == 50) begin
                k = 19'($urandom);
                key_load[1] = 1'b1; key_in[1] = k;
                @(negedge clk);
                key_load[1] = 1'b0;
                kmod[1] = k;
            end
            x = 19'($urandom);
            txn(1, x, 1'b0, 1'b0, 1'b0, '0, 0, res, lat);
            check("rnd_enc", 32'(res), 32'(m_run(x, kmod[1], 4, 1'b0)));
            txn(1, res, 1'b1, 1'b0, 1'b0, '0, 0, res2, lat);
            check("rnd_roundtrip", 32'(res2), 32'(x));
        end

        // ROUNDS=25: rotation wraps past WIDTH
        for (int j = 0; j < 2; j++) begin
            x = (j == 0) ? 19'h7FFFF : 19'h55555;
            txn(2, x, 1'b0, 1'b0, 1'b0, '0, 0, res, lat);
            check("r25_enc", 32'(res), 32'(m_run(x, kmod[2], 25, 1'b0)));
            check("r25_latency", 32'(lat), 25);
            txn(2, res, 1'b1, 1'b0, 1'b0, '0, 0, res2, lat);
            check("r25_roundtrip", 32'(res2), 32'(x));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
